neuron_sample_feeder: RTL and testbench

- Upstream stage of the Neuron training core.
- Stores the training set (x1, x2, t triples) loaded one sample per cycle, then serves samples to the Neuron.
- Serving uses a request/dataReady four-phase handshake and cycles through the set epoch after epoch until the Neuron raises done.
- Provides the sample count for the Neuron's nInput port.

---
 rtl/neuron_pkg.sv | 26 ++
 rtl/sample_ram.sv | 36 +++
 rtl/neuron_sample_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_neuron_sample_feeder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the Neuron training core front end: default
// dimensions, the sample feeder state encoding and the packed sample record.
package neuron_pkg;

    localparam int DEF_DEPTH   = 512;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_X_W     = 7;
    localparam int DEF_T_W     = 2;
    localparam int DEF_EPOCH_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        PRESENT,
        FINISHED
    } feeder_state_t;

    // One training sample as stored in the RAM word: x1 in the MSBs, t in the LSBs.
    typedef struct packed {
        logic signed [DEF_X_W-1:0] x1;
        logic signed [DEF_X_W-1:0] x2;
        logic signed [DEF_T_W-1:0] t;
    } sample_t;

endpackage

// File: rtl/sample_ram.sv
// Training-set storage: one write port, one read port, synchronous write and
// a registered read with one cycle of latency. Contents are never cleared;
// the feeder's sample count decides which words are meaningful.
module sample_ram
    import neuron_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = 2 * DEF_X_W + DEF_T_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write one sample per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; data appears the cycle after re.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/neuron_sample_feeder.sv
// Loads a training set one sample per cycle, then serves it to the Neuron over
// a request/data_ready four-phase handshake, epoch after epoch, until done.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | loading / clearing allowed; start begins serving
//   WAIT     | waiting for request; read address is rd_ptr
//   FETCH    | RAM output valid, captured into the x/t registers
//   PRESENT  | data_ready high until request drops, then rd_ptr advances
//   FINISHED | Neuron reported done; outputs held until clear
module neuron_sample_feeder
    import neuron_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int X_W     = DEF_X_W,
    parameter int T_W     = DEF_T_W,
    parameter int EPOCH_W = DEF_EPOCH_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic signed [X_W-1:0] load_x1,
    input  logic signed [X_W-1:0] load_x2,
    input  logic signed [T_W-1:0] load_t,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  request,
    input  logic                  done,
    output logic signed [X_W-1:0] x1_out,
    output logic signed [X_W-1:0] x2_out,
    output logic signed [T_W-1:0] t_out,
    output logic                  data_ready,
    output logic [31:0]           n_samples,
    output logic [EPOCH_W-1:0]    epoch_count,
    output logic                  full,
    output logic                  overflow,
    output logic                  empty_err,
    output logic                  busy
);

    localparam int              DATA_W     = 2 * X_W + T_W;
    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    feeder_state_t     state;
    feeder_state_t     state_next;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_data;

    logic do_clear;
    logic do_load;
    logic do_drop;
    logic do_start;
    logic start_empty;
    logic rd_en;
    logic capture;
    logic advance;
    logic last_sample;

    sample_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (do_load),
        .wr_addr (wr_ptr),
        .wr_data ({load_x1, load_x2, load_t}),
        .re      (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign full        = (count == COUNT_FULL);
    assign n_samples   = 32'(count);
    assign busy        = (state == WAIT) || (state == FETCH) || (state == PRESENT);
    assign last_sample = ({1'b0, rd_ptr} == count - (ADDR_W + 1)'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle action decode; done outranks request while serving.
    always_comb begin
        state_next  = state;
        do_clear    = 1'b0;
        do_load     = 1'b0;
        do_drop     = 1'b0;
        do_start    = 1'b0;
        start_empty = 1'b0;
        rd_en       = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    do_clear = 1'b1;
                end else if (load_en) begin
                    // A write and start in the same cycle: the write wins.
                    if (full) begin
                        do_drop = 1'b1;
                    end else begin
                        do_load = 1'b1;
                    end
                end else if (start) begin
                    if (count == '0) begin
                        start_empty = 1'b1;
                    end else begin
                        do_start   = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (done) begin
                    state_next = FINISHED;
                end else if (request) begin
                    rd_en      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (done) begin
                    state_next = FINISHED;
                end else begin
                    capture    = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (done) begin
                    state_next = FINISHED;
                end else if (!request) begin
                    advance    = 1'b1;
                    state_next = WAIT;
                end
            end
            FINISHED: begin
                if (clear) begin
                    do_clear   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers, counters, flags and the presented sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            epoch_count <= '0;
            overflow    <= 1'b0;
            x1_out      <= '0;
            x2_out      <= '0;
            t_out       <= '0;
            data_ready  <= 1'b0;
            empty_err   <= 1'b0;
        end else begin
            if (do_clear) begin
                count       <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                epoch_count <= '0;
                overflow    <= 1'b0;
            end
            if (do_load) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                count  <= count + (ADDR_W + 1)'(1);
            end
            if (do_drop) begin
                overflow <= 1'b1;
            end
            if (do_start) begin
                rd_ptr <= '0;
            end
            if (advance) begin
                if (last_sample) begin
                    rd_ptr <= '0;
                    if (epoch_count != {EPOCH_W{1'b1}}) begin
                        epoch_count <= epoch_count + EPOCH_W'(1);
                    end
                end else begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
            if (capture) begin
                x1_out <= rd_data[DATA_W-1 -: X_W];
                x2_out <= rd_data[T_W +: X_W];
                t_out  <= rd_data[T_W-1:0];
            end
            // Registered so it rises one edge after PRESENT is entered and
            // drops on the edge that sees request low or done high.
            data_ready <= (state == PRESENT) && request && !done;
            empty_err  <= start_empty;
        end
    end

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Bench for neuron_sample_feeder: acts as the Neuron on the handshake and
// checks served samples against a queue of what was loaded.
module tb_neuron_sample_feeder;
    import neuron_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0, load_en = 1'b0, clear = 1'b0;
    logic              start = 1'b0, request = 1'b0, done = 1'b0;
    logic signed [6:0] load_x1 = '0, load_x2 = '0;
    logic signed [1:0] load_t = '0;

    logic signed [6:0] x1_0, x2_0, x1_4, x2_4, o_x1, o_x2;
    logic signed [1:0] t_0, t_4, o_t;
    logic [31:0]       n_0, n_4, o_n;
    logic [15:0]       ep_0, ep_4, o_ep;
    logic dr_0, full_0, ovf_0, ee_0, busy_0;
    logic dr_4, full_4, ovf_4, ee_4, busy_4;
    logic o_dr, o_full, o_ovf, o_ee, o_busy;
    logic use4 = 1'b0;

    neuron_sample_feeder dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_x1(load_x1), .load_x2(load_x2),
        .load_t(load_t), .clear(clear), .start(start), .request(request), .done(done),
        .x1_out(x1_0), .x2_out(x2_0), .t_out(t_0), .data_ready(dr_0), .n_samples(n_0),
        .epoch_count(ep_0), .full(full_0), .overflow(ovf_0), .empty_err(ee_0), .busy(busy_0)
    );

    neuron_sample_feeder #(.DEPTH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_x1(load_x1), .load_x2(load_x2),
        .load_t(load_t), .clear(clear), .start(start), .request(request), .done(done),
        .x1_out(x1_4), .x2_out(x2_4), .t_out(t_4), .data_ready(dr_4), .n_samples(n_4),
        .epoch_count(ep_4), .full(full_4), .overflow(ovf_4), .empty_err(ee_4), .busy(busy_4)
    );

    assign o_x1   = use4 ? x1_4   : x1_0;
    assign o_x2   = use4 ? x2_4   : x2_0;
    assign o_t    = use4 ? t_4    : t_0;
    assign o_dr   = use4 ? dr_4   : dr_0;
    assign o_n    = use4 ? n_4    : n_0;
    assign o_ep   = use4 ? ep_4   : ep_0;
    assign o_full = use4 ? full_4 : full_0;
    assign o_ovf  = use4 ? ovf_4  : ovf_0;
    assign o_ee   = use4 ? ee_4   : ee_0;
    assign o_busy = use4 ? busy_4 : busy_0;

    int checks = 0;
    int failures = 0;

    // Reference model: the stored set in load order, the next index to serve
    // and the completed-epoch count.
    sample_t q[$];
    int      m_idx = 0;
    int      m_epoch = 0;
    int      cap = 512;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic sample_t mk(input int a, input int b, input int c);
        sample_t s;
        s.x1 = 7'(a);
        s.x2 = 7'(b);
        s.t  = 2'(c);
        return s;
    endfunction

    function automatic sample_t rand_sample();
        sample_t s;
        s.x1 = 7'($urandom);
        s.x2 = 7'($urandom);
        s.t  = 2'($urandom);
        return s;
    endfunction

    task automatic do_reset();
        load_en = 0; clear = 0; start = 0; request = 0; done = 0;
        rst = 1;
        step();
        rst = 0;
        q.delete();
        m_idx = 0;
        m_epoch = 0;
    endtask

    task automatic load_sample(input sample_t s);
        load_en = 1;
        load_x1 = s.x1;
        load_x2 = s.x2;
        load_t  = s.t;
        step();
        load_en = 0;
        if (q.size() < cap) q.push_back(s);
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    // One full four-phase handshake as the Neuron sees it.
    task automatic handshake(input int hold, input string tag);
        sample_t e;
        int lat;
        e = q[m_idx];
        lat = 0;
        request = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (o_dr === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles after request, want 3", tag, lat);
        end
        if (lat != 0) begin
            checks++;
            if ({o_x1, o_x2, o_t} !== e) begin
                failures++;
                $display("FAIL %s sample[%0d]: got x1=%0d x2=%0d t=%0d, want x1=%0d x2=%0d t=%0d",
                         tag, m_idx, o_x1, o_x2, o_t, e.x1, e.x2, e.t);
            end
            for (int i = 0; i < hold; i++) begin
                step();
                checks++;
                if (o_dr !== 1'b1 || {o_x1, o_x2, o_t} !== e) begin
                    failures++;
                    $display("FAIL %s hold %0d: got dr=%b x1=%0d, want dr=1 x1=%0d",
                             tag, i, o_dr, o_x1, e.x1);
                end
            end
        end
        request = 0;
        step();
        checks++;
        if (o_dr !== 1'b0) begin
            failures++;
            $display("FAIL %s dr_fall: got %b, want 0", tag, o_dr);
        end
        if (m_idx == q.size() - 1) begin
            m_idx = 0;
            if (m_epoch < 65535) m_epoch++;
        end else begin
            m_idx++;
        end
        checks++;
        if (o_ep !== 16'(m_epoch)) begin
            failures++;
            $display("FAIL %s epoch: got %0d, want %0d", tag, o_ep, m_epoch);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({x1_0, x2_0, t_0, dr_0, ee_0, busy_0, ovf_0, full_0} !== '0 || n_0 !== 32'd0 || ep_0 !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs: got x1=%0d dr=%b n=%0d ep=%0d busy=%b full=%b, want all 0",
                     x1_0, dr_0, n_0, ep_0, busy_0, full_0);
        end
        checks++;
        if (n_4 !== 32'd0 || full_4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_depth4: got n=%0d full=%b, want 0 0", n_4, full_4);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load_sample(mk(5, -3, 1));
        load_sample(mk(-7, 2, -1));
        load_sample(mk(0, 1, 1));
        checks++;
        if (o_n !== 32'd3) begin
            failures++;
            $display("FAIL basic n_samples: got %0d, want 3", o_n);
        end
        pulse_start();
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic busy: got %b, want 1", o_busy);
        end
        for (int i = 0; i < 4; i++) handshake(0, "basic");
    endtask

    task automatic test_latency();
        do_reset();
        load_sample(rand_sample());
        load_sample(rand_sample());
        pulse_start();
        handshake(5, "latency");
        handshake(5, "latency_wrap");
    endtask

    task automatic test_random();
        int n;
        do_reset();
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) load_sample(rand_sample());
        checks++;
        if (o_n !== 32'(n)) begin
            failures++;
            $display("FAIL random n_samples: got %0d, want %0d", o_n, n);
        end
        pulse_start();
        for (int i = 0; i < 2 * n + 1; i++) begin
            handshake($urandom_range(0, 3), "random");
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    task automatic test_depth();
        sample_t s;
        use4 = 1;
        cap = 4;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            s = rand_sample();
            load_sample(s);
            checks++;
            if (o_full !== (i >= 4) || o_ovf !== (i >= 5)) begin
                failures++;
                $display("FAIL depth write %0d: got full=%b ovf=%b, want full=%b ovf=%b",
                         i, o_full, o_ovf, i >= 4, i >= 5);
            end
        end
        checks++;
        if (o_n !== 32'd4) begin
            failures++;
            $display("FAIL depth n_samples: got %0d, want 4", o_n);
        end
        pulse_start();
        for (int i = 0; i < 5; i++) handshake(0, "depth");
        use4 = 0;
        cap = 512;
    endtask

    task automatic test_empty_start();
        do_reset();
        pulse_start();
        checks++;
        if (o_ee !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL empty pulse: got ee=%b busy=%b, want 1 0", o_ee, o_busy);
        end
        step();
        checks++;
        if (o_ee !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL empty width: got ee=%b busy=%b, want 0 0", o_ee, o_busy);
        end
        start = 1;
        load_sample(mk(-4, 3, -2));
        start = 0;
        checks++;
        if (o_n !== 32'd1 || o_busy !== 1'b0 || o_ee !== 1'b0) begin
            failures++;
            $display("FAIL load_and_start: got n=%0d busy=%b ee=%b, want 1 0 0", o_n, o_busy, o_ee);
        end
        pulse_start();
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL start_after_load busy: got %b, want 1", o_busy);
        end
        handshake(1, "after_load");
    endtask

    task automatic test_done();
        sample_t last;
        bit seen;
        do_reset();
        load_sample(rand_sample());
        last = rand_sample();
        load_sample(last);
        pulse_start();
        handshake(0, "done_pre");
        request = 1;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = (o_dr === 1'b1);
        end
        done = 1;
        step();
        done = 0;
        checks++;
        if (!seen || o_dr !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL done: got seen=%b dr=%b busy=%b, want 1 0 0", seen, o_dr, o_busy);
        end
        checks++;
        if (o_ep !== 16'd0 || o_x1 !== last.x1 || o_t !== last.t) begin
            failures++;
            $display("FAIL done_hold: got ep=%0d x1=%0d t=%0d, want 0 %0d %0d", o_ep, o_x1, o_t, last.x1, last.t);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_dr !== 1'b0) seen = 1;
        end
        request = 0;
        pulse_start();
        checks++;
        if (seen || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL finished: got dr_seen=%b busy=%b, want 0 0", seen, o_busy);
        end
        clear = 1;
        step();
        clear = 0;
        checks++;
        if (o_n !== 32'd0 || o_ep !== 16'd0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL clear: got n=%0d ep=%0d busy=%b, want 0 0 0", o_n, o_ep, o_busy);
        end
        pulse_start();
        checks++;
        if (o_ee !== 1'b1) begin
            failures++;
            $display("FAIL clear_idle ee: got %b, want 1", o_ee);
        end
    endtask

    task automatic test_rst_fetch();
        do_reset();
        load_sample(mk(5, -3, 1));
        load_sample(mk(-7, 2, -1));
        pulse_start();
        handshake(1, "rst_pre");
        request = 1;
        step();
        rst = 1;
        step();
        rst = 0;
        request = 0;
        q.delete();
        m_idx = 0;
        m_epoch = 0;
        checks++;
        if ({x1_0, x2_0, t_0, dr_0, busy_0, ovf_0, full_0, ee_0} !== '0 || n_0 !== 32'd0 || ep_0 !== 16'd0) begin
            failures++;
            $display("FAIL rst_fetch: got x1=%0d t=%0d dr=%b busy=%b n=%0d, want all 0",
                     x1_0, t_0, dr_0, busy_0, n_0);
        end
        pulse_start();
        checks++;
        if (o_ee !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_fetch start: got ee=%b busy=%b, want 1 0", o_ee, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        for (int r = 0; r < 4; r++) test_random();
        test_depth();
        test_empty_start();
        test_done();
        test_rst_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
